// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-player motion sequencer.
// Turns held-key levels into paced updates of position, jump arc, sword
// level, thrown-sword flight and the leg animation bit. Owns the game-tick
// pacing: a sub-step pulse every TICK_DIV/SWORD_SUB clocks, and a tick on
// every SWORD_SUB-th sub-step.
module player_motion_ctrl #(
  parameter int          TICK_DIV   = 100000,
  parameter int          SWORD_SUB  = 4,
  parameter int          JUMP_H     = 200,
  parameter logic [11:0] X_MAX      = 12'd700,
  parameter logic [11:0] X_INIT     = 12'd0,
  parameter int          LEG_PERIOD = 60
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        pos_reset,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_jump,
  input  logic        key_throw,
  input  logic        key_sword_up,
  input  logic        key_sword_down,
  output logic        tick,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic [1:0]  sword_lvl,
  output logic [11:0] sword_x,
  output logic [1:0]  sword_state,
  output logic        airborne,
  output logic        legs
);

  localparam int SUB_DIV = TICK_DIV / SWORD_SUB;
  localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int STEP_W  = (SWORD_SUB > 1) ? $clog2(SWORD_SUB) : 1;

  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SUB_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SWORD_SUB - 1);
  localparam logic [11:0]       JUMP_TOP  = 12'(JUMP_H);
  localparam logic [11:0]       WALK_LAST = 12'(LEG_PERIOD - 1);

  typedef enum logic [1:0] {
    V_GROUND = 2'd0,
    V_RISE   = 2'd1,
    V_FALL   = 2'd2
  } vert_state_t;

  typedef enum logic [1:0] {
    S_HELD   = 2'd0,
    S_FLYING = 2'd1,
    S_LANDED = 2'd2
  } sword_state_t;

  // Pacing counters
  logic [SUB_W-1:0]  sub_cnt_reg;
  logic [STEP_W-1:0] step_cnt_reg;
  logic              sub_step;
  logic              tick_int;

  // Motion state
  logic [11:0]  x_pos_reg,     x_pos_next;
  logic [11:0]  y_pos_reg,     y_pos_next;
  vert_state_t  vert_reg,      vert_next;
  logic [1:0]   sword_lvl_reg, sword_lvl_next;
  logic [11:0]  sword_x_reg,   sword_x_next;
  sword_state_t sword_reg,     sword_next;
  logic [11:0]  walk_cnt_reg,  walk_cnt_next;
  logic         legs_reg,      legs_next;
  logic         moved;

  // A sub-step is the cycle sub_cnt wraps; a tick is the last sub-step of a tick period.
  assign sub_step = (sub_cnt_reg == SUB_LAST);
  assign tick_int = sub_step && (step_cnt_reg == STEP_LAST);

  // Pacing counters: restart from zero on reset and on a round restart.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      sub_cnt_reg  <= '0;
      step_cnt_reg <= '0;
    end else if (pos_reset) begin
      sub_cnt_reg  <= '0;
      step_cnt_reg <= '0;
    end else if (sub_step) begin
      sub_cnt_reg  <= '0;
      step_cnt_reg <= (step_cnt_reg == STEP_LAST) ? '0 : step_cnt_reg + STEP_W'(1);
    end else begin
      sub_cnt_reg  <= sub_cnt_reg + SUB_W'(1);
    end
  end

  // Next-state logic for movement, jump arc, sword level, sword flight and legs.
  always_comb begin
    x_pos_next     = x_pos_reg;
    y_pos_next     = y_pos_reg;
    vert_next      = vert_reg;
    sword_lvl_next = sword_lvl_reg;
    sword_x_next   = sword_x_reg;
    sword_next     = sword_reg;
    walk_cnt_next  = walk_cnt_reg;
    legs_next      = legs_reg;
    moved          = 1'b0;

    if (tick_int) begin
      // Saturation is tested before the step so the 12-bit value never wraps.
      if (key_left && !key_right && (x_pos_reg != 12'd0)) begin
        x_pos_next = x_pos_reg - 12'd1;
        moved      = 1'b1;
      end else if (key_right && !key_left && (x_pos_reg < X_MAX)) begin
        x_pos_next = x_pos_reg + 12'd1;
        moved      = 1'b1;
      end

      // Only ticks that really changed x advance the walk cadence.
      if (moved) begin
        if (walk_cnt_reg >= WALK_LAST) begin
          walk_cnt_next = 12'd0;
          legs_next     = ~legs_reg;
        end else begin
          walk_cnt_next = walk_cnt_reg + 12'd1;
        end
      end else begin
        walk_cnt_next = 12'd0;
      end

      case (vert_reg)
        V_GROUND: begin
          if (key_jump) begin
            vert_next  = V_RISE;
            y_pos_next = 12'd1;
          end
        end
        V_RISE: begin
          if (y_pos_reg >= JUMP_TOP) begin
            vert_next  = V_FALL;
            y_pos_next = JUMP_TOP - 12'd1;
          end else begin
            y_pos_next = y_pos_reg + 12'd1;
          end
        end
        V_FALL: begin
          // Landing tick lands in GROUND, so a held jump restarts one tick later.
          if (y_pos_reg <= 12'd1) begin
            vert_next  = V_GROUND;
            y_pos_next = 12'd0;
          end else begin
            y_pos_next = y_pos_reg - 12'd1;
          end
        end
        default: begin
          vert_next  = V_GROUND;
          y_pos_next = 12'd0;
        end
      endcase

      // The sword can only be raised or lowered while in hand.
      if (sword_reg == S_HELD) begin
        if (key_sword_up && !key_sword_down && (sword_lvl_reg < 2'd2)) begin
          sword_lvl_next = sword_lvl_reg + 2'd1;
        end else if (key_sword_down && !key_sword_up && (sword_lvl_reg != 2'd0)) begin
          sword_lvl_next = sword_lvl_reg - 2'd1;
        end
      end
    end

    case (sword_reg)
      S_HELD: begin
        // Throw starts from the pre-move x; the throw cycle does not advance it.
        if (tick_int && key_throw) begin
          sword_next   = S_FLYING;
          sword_x_next = x_pos_reg;
        end
      end
      S_FLYING: begin
        if (sub_step) begin
          if (({1'b0, sword_x_reg} + 13'd1) >= {1'b0, X_MAX}) begin
            sword_x_next = X_MAX;
            sword_next   = S_LANDED;
          end else begin
            sword_x_next = sword_x_reg + 12'd1;
          end
        end
      end
      S_LANDED: begin
        // Pickup compares against x before this tick's move.
        if (tick_int && (x_pos_reg == sword_x_reg)) begin
          sword_next     = S_HELD;
          sword_lvl_next = 2'd1;
        end
      end
      default: begin
        sword_next = S_HELD;
      end
    endcase
  end

  // State registers: reset and round restart both return to the initial pose.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      x_pos_reg     <= X_INIT;
      y_pos_reg     <= 12'd0;
      vert_reg      <= V_GROUND;
      sword_lvl_reg <= 2'd1;
      sword_x_reg   <= 12'd0;
      sword_reg     <= S_HELD;
      walk_cnt_reg  <= 12'd0;
      legs_reg      <= 1'b0;
    end else if (pos_reset) begin
      x_pos_reg     <= X_INIT;
      y_pos_reg     <= 12'd0;
      vert_reg      <= V_GROUND;
      sword_lvl_reg <= 2'd1;
      sword_x_reg   <= 12'd0;
      sword_reg     <= S_HELD;
      walk_cnt_reg  <= 12'd0;
      legs_reg      <= 1'b0;
    end else begin
      x_pos_reg     <= x_pos_next;
      y_pos_reg     <= y_pos_next;
      vert_reg      <= vert_next;
      sword_lvl_reg <= sword_lvl_next;
      sword_x_reg   <= sword_x_next;
      sword_reg     <= sword_next;
      walk_cnt_reg  <= walk_cnt_next;
      legs_reg      <= legs_next;
    end
  end

  assign tick        = tick_int;
  assign x_pos       = x_pos_reg;
  assign y_pos       = y_pos_reg;
  assign sword_lvl   = sword_lvl_reg;
  assign sword_x     = sword_x_reg;
  assign sword_state = sword_reg;
  assign airborne    = (vert_reg != V_GROUND);
  assign legs        = legs_reg;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed key sequences, a cycle-level
// behavioural model compared every cycle, and hand-computed spot checks.
module tb_player_motion_ctrl;

  localparam int TICK_DIV   = 8;
  localparam int SWORD_SUB  = 4;
  localparam int JUMP_H     = 4;
  localparam int X_MAX      = 20;
  localparam int X_INIT     = 10;
  localparam int LEG_PERIOD = 3;
  localparam int SUB_DIV    = TICK_DIV / SWORD_SUB;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b0;
  logic        pos_reset = 1'b0;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic        key_jump = 1'b0;
  logic        key_throw = 1'b0;
  logic        key_sword_up = 1'b0;
  logic        key_sword_down = 1'b0;
  logic        tick;
  logic [11:0] x_pos;
  logic [11:0] y_pos;
  logic [1:0]  sword_lvl;
  logic [11:0] sword_x;
  logic [1:0]  sword_state;
  logic        airborne;
  logic        legs;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk_50MHz = ~clk_50MHz;

  player_motion_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .SWORD_SUB (SWORD_SUB),
    .JUMP_H    (JUMP_H),
    .X_MAX     (12'(X_MAX)),
    .X_INIT    (12'(X_INIT)),
    .LEG_PERIOD(LEG_PERIOD)
  ) dut (
    .clk_50MHz     (clk_50MHz),
    .rst           (rst),
    .pos_reset     (pos_reset),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_jump      (key_jump),
    .key_throw     (key_throw),
    .key_sword_up  (key_sword_up),
    .key_sword_down(key_sword_down),
    .tick          (tick),
    .x_pos         (x_pos),
    .y_pos         (y_pos),
    .sword_lvl     (sword_lvl),
    .sword_x       (sword_x),
    .sword_state   (sword_state),
    .airborne      (airborne),
    .legs          (legs)
  );

  // Model: cycle count since restart, jump as a position along a 2*JUMP_H arc,
  // sword flight as throw origin plus sub-steps flown.
  typedef struct packed {
    int cyc;
    int x;
    int arc;
    int lvl;
    int sst;
    int throw_x;
    int steps;
    int walk;
    int legs;
  } model_t;

  model_t m;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.cyc = 0; r.x = X_INIT; r.arc = 0; r.lvl = 1; r.sst = 0;
    r.throw_x = 0; r.steps = 0; r.walk = 0; r.legs = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t mo, input logic pr, input logic kl,
                                       input logic kr, input logic kj, input logic kt,
                                       input logic ku, input logic kd);
    model_t n;
    bit tk;
    bit ss;
    int nx;
    int flown;
    n = mo;
    if (pr) return model_reset();
    tk = (mo.cyc % TICK_DIV) == TICK_DIV - 1;
    ss = (mo.cyc % SUB_DIV) == SUB_DIV - 1;
    n.cyc = mo.cyc + 1;
    flown = clamp(mo.throw_x + mo.steps, 0, X_MAX);
    if (tk) begin
      nx = clamp(mo.x + int'(kr) - int'(kl), 0, X_MAX);
      if (nx != mo.x) begin
        n.walk = mo.walk + 1;
        if (n.walk == LEG_PERIOD) begin
          n.walk = 0;
          n.legs = 1 - mo.legs;
        end
      end else begin
        n.walk = 0;
      end
      n.x = nx;
      if (mo.arc != 0) n.arc = (mo.arc + 1) % (2 * JUMP_H);
      else if (kj) n.arc = 1;
      if (mo.sst == 0) begin
        n.lvl = clamp(mo.lvl + int'(ku) - int'(kd), 0, 2);
        if (kt) begin
          n.sst = 1;
          n.throw_x = mo.x;
          n.steps = 0;
        end
      end else if (mo.sst == 2 && mo.x == flown) begin
        n.sst = 0;
        n.lvl = 1;
      end
    end
    if (ss && mo.sst == 1) begin
      n.steps = mo.steps + 1;
      if (mo.throw_x + n.steps >= X_MAX) n.sst = 2;
    end
    return n;
  endfunction

  function automatic int exp_y(input model_t mo);
    return (mo.arc <= JUMP_H) ? mo.arc : 2 * JUMP_H - mo.arc;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state advances on the same edges as the design.
  always @(posedge clk_50MHz or negedge rst) begin
    if (!rst) m <= model_reset();
    else      m <= model_step(m, pos_reset, key_left, key_right, key_jump, key_throw,
                              key_sword_up, key_sword_down);
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_50MHz) begin
    if (chk_en) begin
      check("m_tick", int'(tick), ((m.cyc % TICK_DIV) == TICK_DIV - 1) ? 1 : 0);
      check("m_x_pos", int'(x_pos), m.x);
      check("m_y_pos", int'(y_pos), exp_y(m));
      check("m_airborne", int'(airborne), (m.arc != 0) ? 1 : 0);
      check("m_sword_lvl", int'(sword_lvl), m.lvl);
      check("m_sword_state", int'(sword_state), m.sst);
      check("m_legs", int'(legs), m.legs);
      if (m.sst != 0) check("m_sword_x", int'(sword_x), clamp(m.throw_x + m.steps, 0, X_MAX));
    end
  end

  // Returns at the falling edge inside the next tick cycle (bounded wait).
  task automatic wait_tick();
    int n;
    n = 0;
    @(negedge clk_50MHz);
    while (!tick && n < 3 * TICK_DIV) begin
      @(negedge clk_50MHz);
      n++;
    end
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  // Waits through one tick and lands on the cycle showing its results.
  task automatic step_tick();
    wait_tick();
    @(negedge clk_50MHz);
  endtask

  int xr_tab[12]   = '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 20, 20};
  int legs_tab[12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  int y_tab[10]    = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
  int air_tab[10]  = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
  int lvl_tab[7]   = '{2, 2, 2, 2, 1, 0, 0};

  initial begin
    int cnt;
    int n;
    repeat (3) @(negedge clk_50MHz);
    chk_en = 1'b1;
    check("rst_x_pos", int'(x_pos), 10);
    check("rst_sword_lvl", int'(sword_lvl), 1);
    check("rst_sword_state", int'(sword_state), 0);
    check("rst_tick", int'(tick), 0);
    rst = 1'b1;

    // Idle: ticks at cycles 7, 15, 23 after release.
    cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk_50MHz);
      if (tick) cnt++;
      if (k % 8 == 7) check("s1_tick_cycle", int'(tick), 1);
    end
    check("s1_tick_count", cnt, 3);
    check("s1_x_pos", int'(x_pos), 10);

    // Walk right into the wall.
    key_right = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step_tick();
      check("s2_x_pos", int'(x_pos), xr_tab[i]);
      check("s2_legs", int'(legs), legs_tab[i]);
    end
    key_right = 1'b0;

    // Held jump: full arc, one ground tick, then a new jump.
    key_jump = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_tick();
      check("s3_y_pos", int'(y_pos), y_tab[i]);
      check("s3_airborne", int'(airborne), air_tab[i]);
    end
    key_jump = 1'b0;
    repeat (6) step_tick();
    check("s3_landed_y", int'(y_pos), 0);
    check("s3_landed_air", int'(airborne), 0);

    // Back to x=10.
    key_left = 1'b1;
    repeat (10) step_tick();
    key_left = 1'b0;
    check("walk_left_x", int'(x_pos), 10);

    // Sword level: up x3, both x1, down x3, then up x2 back to 2.
    for (int i = 0; i < 7; i++) begin
      key_sword_up   = (i < 4);
      key_sword_down = (i >= 3);
      step_tick();
      check("s5_sword_lvl", int'(sword_lvl), lvl_tab[i]);
    end
    key_sword_down = 1'b0;
    key_sword_up   = 1'b1;
    step_tick();
    step_tick();
    key_sword_up = 1'b0;
    check("s5_lvl_raised", int'(sword_lvl), 2);

    // Throw from x=10 with sword_down held during the flight.
    key_throw = 1'b1;
    step_tick();
    key_throw = 1'b0;
    key_sword_down = 1'b1;
    check("s4_throw_state", int'(sword_state), 1);
    check("s4_throw_x", int'(sword_x), 10);
    for (int s = 1; s <= 10; s++) begin
      repeat (2) @(negedge clk_50MHz);
      check("s4_flight_x", int'(sword_x), 10 + s);
      check("s4_flight_state", int'(sword_state), (s == 10) ? 2 : 1);
    end
    check("s4_lvl_frozen", int'(sword_lvl), 2);
    key_sword_down = 1'b0;
    key_right = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step_tick();
      check("s4_walk_x", int'(x_pos), (10 + i > 20) ? 20 : 10 + i);
      if (i == 10) check("s4_still_landed", int'(sword_state), 2);
    end
    key_right = 1'b0;
    check("s4_pickup_state", int'(sword_state), 0);
    check("s4_pickup_lvl", int'(sword_lvl), 1);

    // Round restart mid-jump and mid-flight.
    key_left = 1'b1;
    repeat (10) step_tick();
    key_left = 1'b0;
    key_jump = 1'b1;
    key_throw = 1'b1;
    step_tick();
    key_throw = 1'b0;
    step_tick();
    step_tick();
    key_jump = 1'b0;
    check("s6_pre_y", int'(y_pos), 3);
    check("s6_pre_state", int'(sword_state), 1);
    check("s6_pre_sword_x", int'(sword_x), 18);
    pos_reset = 1'b1;
    @(negedge clk_50MHz);
    pos_reset = 1'b0;
    check("s6_y_pos", int'(y_pos), 0);
    check("s6_x_pos", int'(x_pos), 10);
    check("s6_sword_state", int'(sword_state), 0);
    check("s6_airborne", int'(airborne), 0);
    n = 1;
    while (!tick && n < 3 * TICK_DIV) begin
      @(negedge clk_50MHz);
      n++;
    end
    check("s6_tick_gap", n, 8);
    @(negedge clk_50MHz);

    // Asynchronous reset between clock edges.
    key_right = 1'b1;
    step_tick();
    step_tick();
    key_right = 1'b0;
    check("s6_pre_rst_x", int'(x_pos), 12);
    @(posedge clk_50MHz);
    #3;
    rst = 1'b0;
    #1;
    check("s6_async_x", int'(x_pos), 10);
    check("s6_async_y", int'(y_pos), 0);
    check("s6_async_lvl", int'(sword_lvl), 1);
    check("s6_async_tick", int'(tick), 0);
    @(negedge clk_50MHz);
    rst = 1'b1;
    repeat (10) @(negedge clk_50MHz);
    check("end_x_pos", int'(x_pos), 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
Per-player motion sequencer. It converts held-key levels from the keyboard decoder into paced updates of position, jump arc, sword level, sword flight and the leg animation bit. It owns the game-tick pacing, so the keyboard decoder only reports which keys are held. One instance is used per player, and its outputs feed the sprite/draw pipeline.

Parameters:
TICK_DIV, 100000, clk cycles per game tick; must be a multiple of SWORD_SUB.
SWORD_SUB, 4, sword flight steps per game tick.
JUMP_H, 200, apex height of a jump in pixels.
X_MAX, 12'd700, maximum x for the player and the sword.
X_INIT, 12'd0, x_pos value after reset or pos_reset.
LEG_PERIOD, 60, walking ticks between leg-bit toggles.

Ports:
clk_50MHz  input  1  system clock
rst  input  1  asynchronous reset, active-low
pos_reset  input  1  synchronous round restart, active-high
key_left  input  1  held level
key_right  input  1  held level
key_jump  input  1  held level
key_throw  input  1  held level
key_sword_up  input  1  held level
key_sword_down  input  1  held level
tick  output  1  one-cycle game-tick pulse
x_pos  output  12  player x
y_pos  output  12  height above ground
sword_lvl  output  2  sword height: 0 low, 1 mid, 2 high
sword_x  output  12  thrown-sword x, valid when sword_state != HELD
sword_state  output  2  0 HELD, 1 FLYING, 2 LANDED
airborne  output  1  asserted when vertical state != GROUND
legs  output  1  leg animation phase

Behaviour:
- Priority: rst low > pos_reset > normal operation.
- Reset values, applied on rst low and also by pos_reset:
  - x_pos=X_INIT; y_pos=0; sword_lvl=1; sword_x=0; sword_state=HELD; legs=0.
  - airborne=0; tick=0; all counters 0; vertical FSM in GROUND.
- Pacing:
  - sub_cnt counts 0..TICK_DIV/SWORD_SUB-1. A sub-step pulse occurs on the cycle sub_cnt wraps.
  - A second counter counts sub-steps modulo SWORD_SUB. tick is asserted in the same cycle as every SWORD_SUB-th sub-step, i.e. one cycle every TICK_DIV clocks. The first tick is at cycle TICK_DIV-1 after reset release.
  - All state below changes only on tick or sub-step cycles. Outputs are registered and update on that clock edge.
- Horizontal movement, on tick, in any vertical state:
  - left only: x_pos-1, saturating at 0.
  - right only: x_pos+1, saturating at X_MAX.
  - both or neither held: no move.
- Vertical FSM, evaluated on tick:
  - GROUND: if key_jump, go to RISE and set y_pos=1.
  - RISE: if y_pos==JUMP_H, go to FALL and set y_pos=JUMP_H-1; otherwise y_pos+1.
  - FALL: y_pos-1; if y_pos==1, set y_pos=0 and go to GROUND.
  - Holding jump through a landing starts a new jump no earlier than the tick after the landing tick, so there is at least one GROUND tick between jumps.
  - A full arc is 2*JUMP_H ticks.
- Sword level, on tick, only in HELD:
  - up only: +1, saturating at 2.
  - down only: -1, saturating at 0.
  - both held: no change.
- Sword FSM:
  - HELD: on tick with key_throw, go to FLYING and set sword_x=x_pos. Throwing is allowed while airborne.
  - FLYING: on every sub-step, sword_x+1. When sword_x reaches X_MAX, hold it there and go to LANDED. The throw tick itself does not also advance sword_x.
  - LANDED: on tick, if x_pos==sword_x (compared before this tick's move), go to HELD and set sword_lvl=1.
  - key_throw is ignored outside HELD. Holding it after a pickup throws again on the next tick.
- Legs:
  - walk_cnt increments on each tick where x_pos actually changed.
  - When walk_cnt reaches LEG_PERIOD-1 on a moving tick, legs toggles and walk_cnt returns to 0.
  - A tick with no movement, including a saturated push against a wall, clears walk_cnt and leaves legs unchanged.
- pos_reset mid-jump or mid-flight: all state returns to reset values on the next edge. The pacing counters restart from 0.
- Widths: all arithmetic is 12-bit. Saturation checks happen before the add/subtract, so no wrap-around can occur.

Test Plan:
Parameters for all scenarios: TICK_DIV=8, SWORD_SUB=4, JUMP_H=4, X_MAX=20, X_INIT=10, LEG_PERIOD=3.
1. Reset release, no keys held -> tick pulses at cycles 7, 15, 23; every output stays at its reset value; x_pos=10.
2. key_right held for 12 ticks -> x_pos goes 11..20 and then stays at 20. legs toggles after ticks 3, 6 and 9. At the wall walk_cnt clears, so legs makes no further toggles.
3. key_jump held for 10 ticks -> y_pos sequence 1,2,3,4,3,2,1,0,1,2; airborne=0 exactly on the landing tick.
4. x_pos=10, key_throw pulsed across one tick -> sword_state=FLYING with sword_x=10. sword_x then advances by 1 every 2 clocks and reaches 20 after 10 sub-steps, with sword_state=LANDED. Walking right until x_pos=20 returns sword_state to HELD and sets sword_lvl=1.
5. key_sword_up held for 3 ticks, then both up and down held, then down held for 3 ticks -> sword_lvl 2, 2, 2, then 2, then 1, 0, 0. With the sword FLYING, key_sword_down held -> no change to sword_lvl.
6. pos_reset asserted at y_pos=3 while FLYING -> next edge gives y_pos=0, x_pos=10, sword_state=HELD, and the next tick arrives 8 cycles later. rst asserted asynchronously mid-cycle -> outputs go to reset values immediately, with no clock edge.
